conv_layer_core_p: RTL and testbench

- Parametrised successor of the per-layer convolution engines (fire*_expand*, fire*_squeeze*).
- One engine covers any KxK kernel and channel depth. It drives an external weight ROM and takes an external bias bank.
- DSP_NO parallel lanes share one streamed input pixel. Each lane adds bias, applies optional ReLU, and emits a rounded, saturated fixed-point output per output pixel.
- Adds async reset, stall tolerance, saturation and an explicit layer-done/finish handshake, none of which the per-layer engines have.

---
 rtl/conv_layer_core_p.sv | 143 ++++++++++++++
 tb/tb_conv_layer_core_p.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_layer_core_p.sv
// Streamed KxK convolution engine: DSP_NO lanes share one pixel term per cycle. Each lane
// multiplies, accumulates, adds bias, rounds, applies ReLU and saturates.
module conv_layer_core_p #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned DSP_NO     = 256,
  parameter int unsigned CHIN       = 112,
  parameter int unsigned KERNEL_DIM = 1,
  parameter int unsigned WOUT       = 8,
  parameter int unsigned FRAC_SHIFT = 14,
  parameter int unsigned RELU_EN    = 1,
  localparam int unsigned DOT_LEN   = KERNEL_DIM * KERNEL_DIM * CHIN,
  localparam int unsigned AW        = (DOT_LEN > 1) ? $clog2(DOT_LEN) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       layer_en_i,
  input  logic [WIDTH-1:0]           ifm_i,
  output logic [AW-1:0]              weight_rom_address,
  input  logic [DSP_NO*WIDTH-1:0]    ker_i,
  input  logic [DSP_NO*2*WIDTH-1:0]  bias_i,
  input  logic                       ram_feedback,
  output logic [DSP_NO*WIDTH-1:0]    ofm,
  output logic                       layer_sample,
  output logic                       layer_done,
  output logic                       layer_finish
);

  localparam int unsigned NPIX = WOUT * WOUT;
  localparam int unsigned PW   = $clog2(NPIX + 1);
  localparam int unsigned PW2  = 2 * WIDTH;
  localparam int unsigned RSW  = PW2 + 1;
  localparam int unsigned RW   = PW2 + 2;
  localparam logic signed [RW-1:0] HALF  = RW'(1) <<< (FRAC_SHIFT - 1);
  localparam logic signed [RW-1:0] MAX_V = (RW'(1) <<< (WIDTH - 1)) - RW'(1);
  localparam logic signed [RW-1:0] MIN_V = -MAX_V - RW'(1);

  logic [AW-1:0] addr_q;
  logic [PW-1:0] issued_q, pix_q;
  logic          accept, tap_last;
  logic          done_q, sample_q, ram_fb_q;

  logic                    s1_valid_q, s1_first_q, s1_last_q;
  logic signed [WIDTH-1:0] s1_ifm_q;
  logic [DSP_NO*WIDTH-1:0] s1_ker_q;
  logic                    s2_valid_q, s2_first_q, s2_last_q;
  logic                    s3_last_q, s4_valid_q;

  assign tap_last = (addr_q == AW'(DOT_LEN - 1));
  // Stop accepting once the final pixel's last tap is in flight, so nothing trails the layer.
  assign accept   = layer_en_i && !done_q && (issued_q != PW'(NPIX));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q     <= '0;
      issued_q   <= '0;
      s1_valid_q <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_ifm_q   <= '0;
      s1_ker_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_first_q <= 1'b0;
      s2_last_q  <= 1'b0;
      s3_last_q  <= 1'b0;
      s4_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        addr_q     <= tap_last ? '0 : addr_q + AW'(1);
        s1_ifm_q   <= $signed(ifm_i);
        s1_ker_q   <= ker_i;
        s1_first_q <= (addr_q == '0);
        s1_last_q  <= tap_last;
        if (tap_last) issued_q <= issued_q + PW'(1);
      end
      s2_valid_q <= s1_valid_q;
      s2_first_q <= s1_first_q;
      s2_last_q  <= s1_valid_q && s1_last_q;
      s3_last_q  <= s2_valid_q && s2_last_q;
      s4_valid_q <= s3_last_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix_q    <= '0;
      done_q   <= 1'b0;
      sample_q <= 1'b0;
      ram_fb_q <= 1'b0;
    end else begin
      sample_q <= s4_valid_q;
      if (s4_valid_q) begin
        pix_q <= pix_q + PW'(1);
        if (pix_q == PW'(NPIX - 1)) done_q <= 1'b1;
      end
      if (ram_feedback) ram_fb_q <= 1'b1;
    end
  end

  for (genvar i = 0; i < DSP_NO; i++) begin : g_lane
    logic signed [WIDTH-1:0] ker_l;
    logic signed [PW2-1:0]   bias_l, prod_d, prod_q, acc_q;
    logic signed [RSW-1:0]   r_q;
    logic signed [RW-1:0]    rnd, shf;
    logic [WIDTH-1:0]        sat, ofm_q;

    assign ker_l  = s1_ker_q[i*WIDTH +: WIDTH];
    assign bias_l = bias_i[i*PW2 +: PW2];
    assign prod_d = PW2'(s1_ifm_q) * PW2'(ker_l);
    assign rnd    = RW'(r_q) + HALF;
    assign shf    = rnd >>> FRAC_SHIFT;

    always_comb begin
      sat = shf[WIDTH-1:0];
      // A negative r always rounds to <= 0, so testing r's sign is enough for ReLU.
      if ((RELU_EN != 0) && r_q[RSW-1]) sat = '0;
      else if (shf > MAX_V)             sat = MAX_V[WIDTH-1:0];
      else if (shf < MIN_V)             sat = MIN_V[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        prod_q <= '0;
        acc_q  <= '0;
        r_q    <= '0;
        ofm_q  <= '0;
      end else begin
        prod_q <= prod_d;
        if (s2_valid_q) acc_q <= s2_first_q ? prod_q : acc_q + prod_q;
        if (s3_last_q)  r_q   <= RSW'(acc_q) + RSW'(bias_l);
        if (s4_valid_q) ofm_q <= sat;
      end
    end

    assign ofm[i*WIDTH +: WIDTH] = ofm_q;
  end

  assign weight_rom_address = addr_q;
  assign layer_sample       = sample_q;
  assign layer_done         = done_q;
  assign layer_finish       = done_q && !ram_fb_q;

endmodule

// File: tb/tb_conv_layer_core_p.sv
// Scoreboard bench for conv_layer_core_p: a ReLU and a linear instance share stimulus; the
// expected lane outputs come from a plain-arithmetic dot-product model.
module tb_conv_layer_core_p;

  localparam int NPIX = 4;

  logic        clk = 1'b0, rst = 1'b0, layer_en_i = 1'b0, ram_feedback = 1'b0;
  logic [15:0] ifm_i = '0;
  logic [1:0]  addr_a, addr_b;
  logic [31:0] ker_i, ofm_a, ofm_b;
  logic [63:0] bias_i;
  logic        samp_a, samp_b, done_a, done_b, fin_a, fin_b;

  logic signed [15:0] rom [4][2];
  logic signed [15:0] px [4];
  logic signed [31:0] bias [2];
  int gap [4];

  typedef struct {
    logic signed [15:0] a0, a1, b0, b1;
    longint             c;
    bit                 d;
  } exp_t;
  exp_t q [$];

  int     total = 0, bad = 0, issued = 0;
  longint cyc = 0;

  assign ker_i  = {rom[addr_a][1], rom[addr_a][0]};
  assign bias_i = {bias[1], bias[0]};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  conv_layer_core_p #(.WIDTH(16), .DSP_NO(2), .CHIN(4), .KERNEL_DIM(1), .WOUT(2),
                      .FRAC_SHIFT(14), .RELU_EN(1)) dut_relu (
    .clk(clk), .rst(rst), .layer_en_i(layer_en_i), .ifm_i(ifm_i),
    .weight_rom_address(addr_a), .ker_i(ker_i), .bias_i(bias_i), .ram_feedback(ram_feedback),
    .ofm(ofm_a), .layer_sample(samp_a), .layer_done(done_a), .layer_finish(fin_a));

  conv_layer_core_p #(.WIDTH(16), .DSP_NO(2), .CHIN(4), .KERNEL_DIM(1), .WOUT(2),
                      .FRAC_SHIFT(14), .RELU_EN(0)) dut_lin (
    .clk(clk), .rst(rst), .layer_en_i(layer_en_i), .ifm_i(ifm_i),
    .weight_rom_address(addr_b), .ker_i(ker_i), .bias_i(bias_i), .ram_feedback(ram_feedback),
    .ofm(ofm_b), .layer_sample(samp_b), .layer_done(done_b), .layer_finish(fin_b));

  task automatic chk(input string name, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Fixed-point reference: exact dot product, 32-bit wrap, bias, round half-up, clamp.
  function automatic logic signed [15:0] ref_out(input int lane, input bit relu);
    longint sum = 0;
    longint r;
    logic signed [31:0] acc;
    for (int k = 0; k < 4; k++) sum += longint'(px[k]) * longint'(rom[k][lane]);
    acc = sum[31:0];
    r = longint'(acc) + longint'(bias[lane]);
    r = (r + 8192) >>> 14;
    if (relu && r < 0) r = 0;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return r[15:0];
  endfunction

  function automatic int rs(input int m);
    return int'($urandom_range(0, 2 * m)) - m;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst && (samp_a || samp_b)) begin
      chk("sample_agree", samp_a, samp_b);
      if (q.size() == 0) chk("unexpected_sample", 1, 0);
      else begin
        e = q.pop_front();
        chk("ofm_relu_l0", $signed(ofm_a[15:0]), e.a0);
        chk("ofm_relu_l1", $signed(ofm_a[31:16]), e.a1);
        chk("ofm_lin_l0", $signed(ofm_b[15:0]), e.b0);
        chk("ofm_lin_l1", $signed(ofm_b[31:16]), e.b1);
        chk("sample_cycle", cyc, e.c);
        chk("done_relu", done_a, e.d);
        chk("done_lin", done_b, e.d);
      end
    end
  end

  task automatic send_pixel();
    bit   acc_ok = (issued < NPIX);
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      chk("rom_addr", addr_a, acc_ok ? k : 0);
      layer_en_i = 1'b1;
      ifm_i = px[k];
      @(posedge clk); #1;
      if (k == 3 && acc_ok) begin
        issued++;
        e.a0 = ref_out(0, 1); e.a1 = ref_out(1, 1);
        e.b0 = ref_out(0, 0); e.b1 = ref_out(1, 0);
        e.c  = cyc + 4;
        e.d  = (issued == NPIX);
        q.push_back(e);
      end
      layer_en_i = 1'b0;
      ifm_i = 16'($urandom);
      for (int g = 0; g < gap[k]; g++) begin
        chk("addr_hold", addr_a, acc_ok ? (k + 1) % 4 : 0);
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_timeout", q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("rst_ofm_relu", ofm_a, 0);
    chk("rst_ofm_lin", ofm_b, 0);
    chk("rst_sample", samp_a | samp_b, 0);
    chk("rst_done", done_a | done_b, 0);
    chk("rst_finish", fin_a | fin_b, 0);
    chk("rst_addr", addr_a | addr_b, 0);
    layer_en_i = 1'b0;
    issued = 0;
    q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic set_w(input int w0, input int w1);
    for (int k = 0; k < 4; k++) begin
      rom[k][0] = 16'(w0);
      rom[k][1] = 16'(w1);
    end
  endtask

  task automatic set_px(input int v);
    for (int k = 0; k < 4; k++) px[k] = 16'(v);
  endtask

  task automatic rand_layer();
    for (int k = 0; k < 4; k++) begin
      rom[k][0] = 16'(rs(16384));
      rom[k][1] = 16'(rs(16384));
    end
    bias[0] = rs(1 << 28);
    bias[1] = rs(1 << 28);
  endtask

  task automatic rand_px(input bit stall);
    for (int k = 0; k < 4; k++) begin
      px[k]  = 16'(rs(16384));
      gap[k] = stall ? int'($urandom_range(0, 2)) : 0;
    end
  endtask

  task automatic feedback_check();
    chk("finish_set", fin_a, 1);
    chk("finish_set_lin", fin_b, 1);
    ram_feedback = 1'b1;
    @(posedge clk); #1;
    ram_feedback = 1'b0;
    chk("finish_clear", fin_a, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("finish_sticky", fin_a, 0);
    chk("done_sticky", done_a, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bias = '{0, 0};
    gap  = '{0, 0, 0, 0};
    set_w(0, 0);
    set_px(0);
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    set_w(4096, 8192); set_px(16384);
    send_pixel(); drain();

    set_w(4096, -4096); bias[0] = 134217728;
    send_pixel(); drain();
    bias[0] = 0;

    set_w(4096, 8192); gap = '{0, 3, 1, 0};
    send_pixel(); drain();
    gap = '{0, 0, 0, 0};

    set_w(1, 1); set_px(8192);
    send_pixel(); drain();
    feedback_check();
    set_px(1234);
    send_pixel();
    repeat (8) @(posedge clk);
    #1;
    chk("addr_after_done", addr_a, 0);

    do_reset();
    set_w(1, -1); set_px(6144);
    send_pixel(); drain();

    // Back-to-back pixels, then an ignored fifth pixel.
    do_reset();
    rand_layer();
    for (int p = 0; p < 5; p++) begin
      rand_px(1'b0);
      send_pixel();
    end
    drain();
    feedback_check();

    // Reset in the middle of the second pixel.
    do_reset();
    rand_layer(); rand_px(1'b0);
    send_pixel(); drain();
    rand_px(1'b0);
    for (int k = 0; k < 2; k++) begin
      layer_en_i = 1'b1; ifm_i = px[k];
      @(posedge clk); #1;
    end
    layer_en_i = 1'b1; ifm_i = px[2];
    do_reset();
    for (int p = 0; p < 4; p++) begin
      rand_px(1'b1);
      send_pixel();
    end
    drain();
    chk("done_after_reset", done_a, 1);

    repeat (4) begin
      do_reset();
      rand_layer();
      for (int p = 0; p < 5; p++) begin
        rand_px(1'b1);
        send_pixel();
      end
      drain();
      chk("done_rand", done_b, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
